// File: rtl/pulse_count_ctrl.sv
// Sequencer for a modulo-4 ones-counter: clears it, drives cmd_len x pulses, counts z rising edges.
// Optional `PULSE_CHECK_EN adds rsp_err = (unsaturated hits != len>>2), latched on entry to RESP.
module pulse_count_ctrl #(
  parameter int LEN_W = 8,
  parameter int HIT_W = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cnt_x,
  output logic             cnt_reset,
  input  logic             cnt_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [HIT_W-1:0] rsp_hits,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [3:0]       GAP_V   = 4'(GAP);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

  state_t           state_r;
  state_t           state_s;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] left_r;
  logic [3:0]       gap_r;
  logic             drain_r;
  logic             z_q;
  logic             x_next_s;
  logic             accept_s;
  logic             hit_s;

  assign accept_s = (state_r == IDLE) && cmd_valid;
  assign hit_s    = cnt_z && !z_q && ((state_r == RUN) || (state_r == DRAIN));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and next-cycle pulse decision; cnt_x is a register, so it is decided one cycle ahead.
  always_comb begin
    state_s  = state_r;
    x_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) state_s = CLR;
        else           state_s = IDLE;
      end
      CLR: begin
        if (len_r != '0) begin
          state_s  = RUN;
          x_next_s = 1'b1;
        end else begin
          state_s  = DRAIN;
        end
      end
      RUN: begin
        if (cnt_x) begin
          if (left_r == LEN_ONE)   state_s  = DRAIN;
          else if (GAP_V == 4'd0)  x_next_s = 1'b1;
          else                     x_next_s = 1'b0;
        end else begin
          if (gap_r == 4'd1) x_next_s = 1'b1;
          else               x_next_s = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_r) state_s = RESP;
        else         state_s = DRAIN;
      end
      RESP: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath, pulse/gap bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_x     <= 1'b0;
      cnt_reset <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_hits  <= '0;
      z_q       <= 1'b0;
      len_r     <= '0;
      left_r    <= '0;
      gap_r     <= 4'd0;
      drain_r   <= 1'b0;
    end else begin
      cnt_x     <= x_next_s;
      cnt_reset <= (state_s == CLR);
      rsp_valid <= (state_s == RESP);
      busy      <= (state_s != IDLE);
      cmd_ready <= (state_s == IDLE);
      drain_r   <= (state_r == DRAIN) ? !drain_r : 1'b0;
      if (accept_s) begin
        len_r    <= cmd_len;
        rsp_hits <= '0;
        z_q      <= 1'b0;
      end else begin
        z_q <= cnt_z;
        if (hit_s && (rsp_hits != HIT_MAX)) rsp_hits <= rsp_hits + HIT_W'(1);
        else                                rsp_hits <= rsp_hits;
      end
      // left_r counts pulses still owed, including the one on cnt_x this cycle.
      if (state_r == CLR)                  left_r <= len_r;
      else if ((state_r == RUN) && cnt_x)  left_r <= left_r - LEN_ONE;
      else                                 left_r <= left_r;
      if ((state_r == RUN) && cnt_x)                 gap_r <= GAP_V;
      else if ((state_r == RUN) && (gap_r != 4'd0))  gap_r <= gap_r - 4'd1;
      else                                           gap_r <= gap_r;
    end
  end

`ifdef PULSE_CHECK_EN
  localparam logic [LEN_W-1:0] RAW_MAX = {LEN_W{1'b1}};

  logic [LEN_W-1:0] raw_r;
  logic [LEN_W-1:0] raw_next_s;
  logic             err_r;

  // Unsaturated hit count, including a hit landing on the RESP entry edge.
  always_comb begin
    raw_next_s = raw_r;
    if (accept_s)                           raw_next_s = '0;
    else if (hit_s && (raw_r != RAW_MAX))   raw_next_s = raw_r + LEN_ONE;
    else                                    raw_next_s = raw_r;
  end

  // Raw count and pass/fail flag, frozen on entry to RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_r <= '0;
      err_r <= 1'b0;
    end else begin
      raw_r <= raw_next_s;
      if (accept_s)                                    err_r <= 1'b0;
      else if ((state_s == RESP) && (state_r != RESP)) err_r <= (raw_next_s != (len_r >> 2));
      else                                             err_r <= err_r;
    end
  end

  assign rsp_err = err_r;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
